axi_rd_arbiter: RTL and testbench

//  Read-side scheduler of the SRAM-like-to-AXI bridge. Arbitrates read requests

---
 rtl/axi_rd_arbiter.sv | 144 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Read-side scheduler: arbitrates inst/data SRAM-like reads onto one AXI AR
// channel, tags each request with a per-requester ARID and routes R beats back by RID.
module axi_rd_arbiter #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned INST_ID   = 0,
  parameter int unsigned DATA_ID   = 1
) (
  input  logic        aclk,
  input  logic        areset,

  input  logic        inst_rd_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_rd_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  input  logic        raw_block,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic {IDLE, AR} state_t;

  state_t              state_q, state_d;
  logic                data_grant, inst_grant;
  logic [CNT_W-1:0]    inst_cnt, data_cnt;
  logic [ID_W-1:0]     arid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [2:0]          arsize_q;
  logic                inst_hit, data_hit;
  logic                inst_dec, data_dec;
  logic                unused_rresp;

  assign unused_rresp = ^rresp;

  // R routing by id; a matching beat always reports data_ok
  assign inst_hit     = rvalid & (rid == ID_W'(INST_ID));
  assign data_hit     = rvalid & (rid == ID_W'(DATA_ID));
  assign inst_data_ok = inst_hit;
  assign data_data_ok = data_hit;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign rready       = 1'b1;

  // Completion only retires a read if one is actually outstanding
  assign inst_dec = inst_hit & rlast & (inst_cnt != '0);
  assign data_dec = data_hit & rlast & (data_cnt != '0);

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and grant: data has fixed priority over inst
  always_comb begin
    state_d    = state_q;
    data_grant = 1'b0;
    inst_grant = 1'b0;
    case (state_q)
      IDLE: begin
        data_grant = data_rd_req & ~raw_block & ~areset &
                     (data_cnt < CNT_W'(MAX_OUTST));
        inst_grant = inst_rd_req & ~areset & ~data_grant &
                     (inst_cnt < CNT_W'(MAX_OUTST));
        if (data_grant || inst_grant) state_d = AR;
      end
      AR: begin
        if (arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_addr_ok = data_grant;
  assign inst_addr_ok = inst_grant;
  assign arvalid      = (state_q == AR);

  // AR payload captured on grant, held stable while arvalid is high
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arid_q   <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
    end else if (data_grant) begin
      arid_q   <= ID_W'(DATA_ID);
      araddr_q <= data_addr;
      arsize_q <= {1'b0, data_size};
    end else if (inst_grant) begin
      arid_q   <= ID_W'(INST_ID);
      araddr_q <= inst_addr;
      arsize_q <= {1'b0, inst_size};
    end
  end

  // Outstanding-read counters; simultaneous inc and dec cancel
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      inst_cnt <= '0;
      data_cnt <= '0;
    end else begin
      inst_cnt <= inst_cnt + CNT_W'(inst_grant) - CNT_W'(inst_dec);
      data_cnt <= data_cnt + CNT_W'(data_grant) - CNT_W'(data_dec);
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arlen   = 8'h00;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (MAX_OUTST=2, INST_ID=0, DATA_ID=1).
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        inst_rd_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_rd_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        raw_block;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;

  axi_rd_arbiter #(.MAX_OUTST(2), .INST_ID(0), .DATA_ID(1)) dut (
    .aclk(aclk), .areset(areset),
    .inst_rd_req(inst_rd_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_rd_req(data_rd_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .raw_block(raw_block),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One R beat with rlast=1 for the given id
  task automatic r_beat(input logic [3:0] id);
    rvalid = 1'b1; rid = id; rlast = 1'b1; rdata = 32'h1234_0000 | 32'(id);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    inst_rd_req = 0; inst_addr = 0; inst_size = 0;
    data_rd_req = 0; data_addr = 0; data_size = 0;
    raw_block = 0; arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    tick(); tick();
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%0h exp=0", arvalid); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL rst_araddr got=%0h exp=0", araddr); end
    checks++; if ({arid, arsize} !== 7'h0) begin errors++; $display("FAIL rst_arid_size got=%0h exp=0", {arid, arsize}); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL rst_addr_ok got=%0b exp=00", {inst_addr_ok, data_addr_ok}); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rst_rready got=%0h exp=1", rready); end
    checks++; if ({arlen, arburst, arlock, arcache, arprot} !== {8'h0, 2'b01, 2'b00, 4'h0, 3'b000})
      begin errors++; $display("FAIL rst_ar_const got=%0h exp=%0h", {arlen, arburst, arlock, arcache, arprot}, {8'h0, 2'b01, 11'h0}); end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_single_inst();
    arready = 1'b1;
    inst_rd_req = 1'b1; inst_addr = 32'h1C00_0000; inst_size = 2'd2;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL t1_addr_ok got=%0b exp=10", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_rd_req = 1'b0;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL t1_arvalid got=%0h exp=1", arvalid); end
    checks++; if (arid !== 4'd0) begin errors++; $display("FAIL t1_arid got=%0h exp=0", arid); end
    checks++; if (araddr !== 32'h1C00_0000) begin errors++; $display("FAIL t1_araddr got=%0h exp=1c000000", araddr); end
    checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL t1_arsize got=%0b exp=010", arsize); end
    tick();
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL t1_ar_done got=%0h exp=0", arvalid); end
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF; rlast = 1'b1;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL t1_data_ok got=%0b exp=10", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata got=%0h exp=deadbeef", inst_rdata); end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_priority();
    arready = 1'b1;
    inst_rd_req = 1'b1; inst_addr = 32'h1C00_0040; inst_size = 2'd2;
    data_rd_req = 1'b1; data_addr = 32'h8000_0010; data_size = 2'd1;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("FAIL t2_prio got=%0b exp=01", {inst_addr_ok, data_addr_ok}); end
    tick();
    data_rd_req = 1'b0;
    #1;
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL t2_ar_no_grant got=%0h exp=0", inst_addr_ok); end
    checks++; if ({arid, araddr, arsize} !== {4'd1, 32'h8000_0010, 3'b001}) begin errors++; $display("FAIL t2_data_ar got=%0h exp=%0h", {arid, araddr, arsize}, {4'd1, 32'h8000_0010, 3'b001}); end
    tick();
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL t2_inst_next got=%0h exp=1", inst_addr_ok); end
    tick();
    inst_rd_req = 1'b0;
    checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h1C00_0040}) begin errors++; $display("FAIL t2_inst_ar got=%0h exp=%0h", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1C00_0040}); end
    tick();
    r_beat(4'd1);
    r_beat(4'd0);
  endtask

  task automatic test_max_outst();
    arready = 1'b1;
    data_addr = 32'h8000_0100; data_size = 2'd2;
    for (int i = 0; i < 2; i++) begin
      data_rd_req = 1'b1;
      #1;
      checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t3_grant%0d got=%0h exp=1", i, data_addr_ok); end
      tick();
      data_rd_req = 1'b0;
      tick();
    end
    data_rd_req = 1'b1; inst_rd_req = 1'b1;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL t3_full_inst_ok got=%0b exp=10", {inst_addr_ok, data_addr_ok}); end
    tick();
    inst_rd_req = 1'b0;
    tick();
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL t3_still_full got=%0h exp=0", data_addr_ok); end
    rvalid = 1'b1; rid = 4'd1; rlast = 1'b1;
    #1;
    checks++; if ({data_data_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL t3_return got=%0b exp=10", {data_data_ok, data_addr_ok}); end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t3_regrant got=%0h exp=1", data_addr_ok); end
    tick();
    data_rd_req = 1'b0;
    tick();
  endtask

  task automatic test_interleave();
    // Outstanding now: data=2, inst=1
    logic [3:0] ids [3];
    ids[0] = 4'd1; ids[1] = 4'd0; ids[2] = 4'd1;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rid = ids[i]; rlast = 1'b1; rdata = 32'hA5A5_0000 + 32'(i);
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== ((ids[i] == 4'd0) ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL t5_route%0d got=%0b exp=%0b", i, {inst_data_ok, data_data_ok}, (ids[i] == 4'd0) ? 2'b10 : 2'b01); end
      checks++; if (data_rdata !== 32'hA5A5_0000 + 32'(i)) begin errors++; $display("FAIL t5_rdata%0d got=%0h exp=%0h", i, data_rdata, 32'hA5A5_0000 + 32'(i)); end
      tick();
    end
    rvalid = 1'b1; rid = 4'd5;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL t5_unknown_rid got=%0b exp=00", {inst_data_ok, data_data_ok}); end
    tick();
    rid = 4'd1;
    #1;
    checks++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL t5_underflow_ok got=%0h exp=1", data_data_ok); end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    // Both counters must be at 0: two grants each, then both blocked
    for (int i = 0; i < 4; i++) begin
      data_rd_req = (i < 2); inst_rd_req = (i >= 2);
      #1;
      checks++; if ({inst_addr_ok, data_addr_ok} !== ((i < 2) ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL t5_cnt_zero%0d got=%0b exp=%0b", i, {inst_addr_ok, data_addr_ok}, (i < 2) ? 2'b01 : 2'b10); end
      tick();
      data_rd_req = 1'b0; inst_rd_req = 1'b0;
      tick();
    end
    data_rd_req = 1'b1; inst_rd_req = 1'b1;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL t5_both_full got=%0b exp=00", {inst_addr_ok, data_addr_ok}); end
    data_rd_req = 1'b0; inst_rd_req = 1'b0;
    r_beat(4'd1); r_beat(4'd1); r_beat(4'd0); r_beat(4'd0);
  endtask

  task automatic test_raw_block();
    arready = 1'b0;
    inst_rd_req = 1'b1; inst_addr = 32'h1C00_0200;
    tick();
    inst_rd_req = 1'b0;
    raw_block = 1'b1; data_rd_req = 1'b1; data_addr = 32'h8000_0300;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({arvalid, araddr, data_addr_ok} !== {1'b1, 32'h1C00_0200, 1'b0})
        begin errors++; $display("FAIL t4_hold%0d got=%0h exp=%0h", i, {arvalid, araddr, data_addr_ok}, {1'b1, 32'h1C00_0200, 1'b0}); end
      tick();
    end
    arready = 1'b1;
    tick();
    checks++; if ({arvalid, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL t4_blocked got=%0b exp=00", {arvalid, data_addr_ok}); end
    raw_block = 1'b0;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t4_unblock got=%0h exp=1", data_addr_ok); end
    tick();
    data_rd_req = 1'b0;
    tick();
    r_beat(4'd0); r_beat(4'd1);
  endtask

  task automatic test_reset_mid();
    arready = 1'b0;
    data_rd_req = 1'b1; data_addr = 32'h8000_0400;
    tick();
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL t6_pre got=%0h exp=1", arvalid); end
    areset = 1'b1;
    #1;
    checks++; if ({arvalid, araddr, data_addr_ok} !== 34'h0) begin errors++; $display("FAIL t6_async got=%0h exp=0", {arvalid, araddr, data_addr_ok}); end
    tick();
    areset = 1'b0; arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_rd_req = 1'b1;
      #1;
      checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t6_cnt_cleared%0d got=%0h exp=1", i, data_addr_ok); end
      tick();
      data_rd_req = 1'b0;
      tick();
    end
    r_beat(4'd1); r_beat(4'd1);
  endtask

  initial begin
    test_reset();
    test_single_inst();
    test_priority();
    test_max_outst();
    test_interleave();
    test_raw_block();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
